dsi_tx_arbiter: RTL and testbench
=================================

// Module: dsi_tx_arbiter
// PURPOSE
//  Shares the DSI lanes controller write interface between a video stream source (HS only) and a command
//  source (HS or LP packets). Grants whole packets, sequences iface_lpm_en setup/hold around LP packets,
//  waits for the lanes to return idle and enforces a minimum inter-packet gap before the next grant.
// PARAMETERS
//  MIN_GAP       4  idle clk_sys cycles between lines_active falling and the next grant (>=1)
//  STARVE_LIMIT  8  consecutive video grants while cmd pending before cmd is forced (DSI_ARB_STARVE_GUARD_EN only)
// PORTS
//  clk_sys          in   1   system clock
//  rst_n            in   1   asynchronous reset, active-low
//  vid_req          in   1   video packet pending; first word valid on vid_data/vid_strb
//  vid_data         in   32  video word
//  vid_strb         in   4   video byte strobes
//  vid_last         in   1   current video word is last of packet
//  vid_ack          out  1   video word consumed; present next word next cycle
//  cmd_req          in   1   command packet pending
//  cmd_data         in   32  command word
//  cmd_strb         in   4   command byte strobes
//  cmd_last         in   1   current command word is last
//  cmd_lp           in   1   1 = LP packet, 0 = HS packet; stable while cmd_req
//  cmd_ack          out  1   command word consumed
//  iface_write_data out  32  to lanes controller, muxed from granted source
//  iface_write_strb out  4   to lanes controller
//  iface_write_rqst out  1   to lanes controller
//  iface_last_word  out  1   to lanes controller
//  iface_lpm_en     out  1   to lanes controller
//  iface_data_rqst  in   1   word request from lanes controller
//  lines_active     in   1   any data lane active
//  clock_ready      in   1   clock lane running in HS
//  grant            out  2   01 video, 10 command, 00 none
//  busy             out  1   state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, gap/starve counters 0.
//  FSM:
//   IDLE: if clock_ready && (vid_req||cmd_req): pick winner, latch grant. HS winner -> XFER; LP cmd -> LP_SETUP.
//   LP_SETUP: iface_lpm_en=1, rqst=0, exactly 1 cycle -> XFER.
//   XFER: iface_write_rqst=1; data/strb combinational from granted source; ack = iface_data_rqst & grant bit.
//     iface_last_word = granted_last & iface_data_rqst. On it: LP -> LP_HOLD, HS -> DRAIN.
//   LP_HOLD: lpm_en=1, rqst=0, 1 cycle -> DRAIN (lpm_en drops 1 cycle after last word).
//   DRAIN: wait lines_active==0 -> GAP.
//   GAP: count MIN_GAP cycles, then grant<=00 -> IDLE.
//  iface_lpm_en=1 in LP_SETUP, XFER (LP grant), LP_HOLD only; 0 for every HS packet.
//  Priority: video strictly over command on simultaneous request; evaluated only in IDLE, never preempts.
//  clock_ready low in IDLE: no grant. clock_ready falling mid-packet: packet completes, then no new grant.
//  Source must hold req and current word until its last ack; dropping req mid-packet is illegal (unchecked).
//  Single-word packet: first iface_data_rqst with last=1 ends XFER; ack and last_word same cycle.
//  lines_active already low on DRAIN entry: DRAIN lasts 1 cycle.
//  Latency: req in IDLE -> rqst next cycle (HS) or 2 cycles (LP).
// CONFIGURATION
//  DSI_ARB_STARVE_GUARD_EN defined: starve counter increments per video grant while cmd_req=1, clears on cmd
//   grant or cmd_req=0; at STARVE_LIMIT the next IDLE decision grants command even if vid_req=1.
//  Not defined: strict video priority, no counter, command may wait indefinitely.
// TESTING
//  HS video A,B,C(last), data_rqst each 2nd cycle -> rqst 1 cycle after vid_req; 3 vid_ack; last_word with C;
//   grant 01 until MIN_GAP=4 cycles after lines_active falls.
//  LP cmd 2 words -> lpm_en rises 1 cycle before rqst, falls 1 cycle after last_word; grant 10.
//  vid_req & cmd_req same cycle (cmd_lp=0) -> grant 01 first; cmd granted on IDLE after video gap.
//  clock_ready=0 with vid_req=1 for 10 cycles -> rqst=0, grant=00; clock_ready=1 -> rqst next cycle.
//  Macro on: 8 back-to-back video packets with cmd pending -> 9th grant=10; macro off -> video keeps grant.
//  rst_n low mid-XFER -> rqst, lpm_en, grant, acks 0 immediately; after release IDLE, new packet clean.

Source files
------------

// File: rtl/dsi_tx_arbiter.sv
// dsi_tx_arbiter
//   Shares the DSI lanes controller write interface between an HS-only video
//   source and a command source that sends HS or LP packets. Whole packets are
//   granted. iface_lpm_en is asserted one cycle before and held one cycle after
//   every LP packet. After each packet the arbiter waits for the lanes to go
//   idle, then holds off for MIN_GAP cycles before it makes the next grant.
//
//   Optional build macro: DSI_ARB_STARVE_GUARD_EN
//     When defined, the command source is forced through after STARVE_LIMIT
//     consecutive video grants made while a command was waiting.
//     When undefined, video has strict priority and a command can wait forever.
//
// Parameters
//   MIN_GAP       idle cycles between lines_active falling and the next grant (>=1)
//   STARVE_LIMIT  video grants tolerated while a command waits (guard build only)
//
// Ports
//   clk_sys, rst_n            clock, asynchronous active-low reset
//   vid_req/data/strb/last    video source word interface
//   vid_ack                   video word consumed; source shows next word next cycle
//   cmd_req/data/strb/last    command source word interface
//   cmd_lp                    command packet is LP (stable while cmd_req)
//   cmd_ack                   command word consumed
//   iface_write_data/strb     word to the lanes controller, from the granted source
//   iface_write_rqst          write request to the lanes controller
//   iface_last_word           last word of the packet is being taken
//   iface_lpm_en              LP mode enable to the lanes controller
//   iface_data_rqst           lanes controller takes a word this cycle
//   lines_active              any data lane active
//   clock_ready               clock lane running in HS
//   grant                     01 video, 10 command, 00 none
//   busy                      arbiter not idle
//
// States
//   state    | meaning
//   IDLE     | no grant; arbitrate when clock_ready and a request is present
//   LP_SETUP | lpm_en raised one cycle ahead of an LP packet
//   XFER     | words pass from the granted source to the lanes controller
//   LP_HOLD  | lpm_en held one cycle after an LP packet's last word
//   DRAIN    | wait for the data lanes to go idle
//   GAP      | MIN_GAP cycles of enforced idle time, then release the grant

module dsi_tx_arbiter #(
  parameter int unsigned MIN_GAP = 4
`ifdef DSI_ARB_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIMIT = 8
`endif
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [31:0] vid_data,
  input  logic [3:0]  vid_strb,
  input  logic        vid_last,
  output logic        vid_ack,
  input  logic        cmd_req,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_strb,
  input  logic        cmd_last,
  input  logic        cmd_lp,
  output logic        cmd_ack,
  output logic [31:0] iface_write_data,
  output logic [3:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  output logic        iface_lpm_en,
  input  logic        iface_data_rqst,
  input  logic        lines_active,
  input  logic        clock_ready,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LP_SETUP = 3'd1,
    S_XFER     = 3'd2,
    S_LP_HOLD  = 3'd3,
    S_DRAIN    = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          lp_q, lp_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          granted_last;
  logic          xfer_last;
  logic          arb_go;
  logic          pick_cmd;

  assign granted_last = grant_q[0] ? vid_last : cmd_last;
  assign xfer_last    = (state_q == S_XFER) && iface_data_rqst && granted_last;
  assign arb_go       = clock_ready && (vid_req || cmd_req);

`ifdef DSI_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  // Once the limit is reached a waiting command beats a pending video packet.
  assign pick_cmd = !vid_req || (cmd_req && (starve_q >= SW'(STARVE_LIMIT)));

  always_comb begin
    starve_d = starve_q;
    if (!cmd_req) begin
      starve_d = '0;
    end else if ((state_q == S_IDLE) && arb_go) begin
      if (pick_cmd) begin
        starve_d = '0;
      end else if (starve_q < SW'(STARVE_LIMIT)) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign pick_cmd = !vid_req;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      lp_q      <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      lp_q      <= lp_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    lp_d      = lp_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arb_go) begin
          if (pick_cmd) begin
            grant_d = 2'b10;
            lp_d    = cmd_lp;
            state_d = cmd_lp ? S_LP_SETUP : S_XFER;
          end else begin
            grant_d = 2'b01;
            lp_d    = 1'b0;
            state_d = S_XFER;
          end
        end
      end
      S_LP_SETUP: state_d = S_XFER;
      S_XFER: begin
        if (xfer_last) begin
          state_d = lp_q ? S_LP_HOLD : S_DRAIN;
        end
      end
      S_LP_HOLD: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!lines_active) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        // Down-counter: GAP lasts MIN_GAP cycles, terminal count at zero.
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          lp_d    = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        lp_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    iface_write_data = '0;
    iface_write_strb = '0;
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    iface_lpm_en     = 1'b0;
    vid_ack          = 1'b0;
    cmd_ack          = 1'b0;
    case (state_q)
      S_LP_SETUP, S_LP_HOLD: iface_lpm_en = 1'b1;
      S_XFER: begin
        iface_write_rqst = 1'b1;
        iface_lpm_en     = lp_q;
        iface_write_data = grant_q[0] ? vid_data : cmd_data;
        iface_write_strb = grant_q[0] ? vid_strb : cmd_strb;
        vid_ack          = iface_data_rqst & grant_q[0];
        cmd_ack          = iface_data_rqst & grant_q[1];
        iface_last_word  = xfer_last;
      end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dsi_tx_arbiter.sv
// Self-checking bench for dsi_tx_arbiter. Sources are queues of words; the
// lanes controller is a small behavioural model. Packet order and per-word
// contents are predicted from the arbitration rules and compared with what
// the lanes controller actually received.
module tb_dsi_tx_arbiter;

  localparam int MIN_GAP      = 4;
  localparam int STARVE_LIMIT = 8;
`ifdef DSI_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        vid_req, vid_last, vid_ack;
  logic [31:0] vid_data;
  logic [3:0]  vid_strb;
  logic        cmd_req, cmd_last, cmd_lp, cmd_ack;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_rqst, iface_last_word, iface_lpm_en;
  logic        iface_data_rqst, lines_active, clock_ready;
  logic [1:0]  grant;
  logic        busy;

  always #5 clk_sys = ~clk_sys;

  dsi_tx_arbiter dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .vid_req(vid_req), .vid_data(vid_data), .vid_strb(vid_strb), .vid_last(vid_last), .vid_ack(vid_ack),
    .cmd_req(cmd_req), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_last(cmd_last), .cmd_lp(cmd_lp),
    .cmd_ack(cmd_ack),
    .iface_write_data(iface_write_data), .iface_write_strb(iface_write_strb),
    .iface_write_rqst(iface_write_rqst), .iface_last_word(iface_last_word), .iface_lpm_en(iface_lpm_en),
    .iface_data_rqst(iface_data_rqst), .lines_active(lines_active), .clock_ready(clock_ready),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {logic lp; logic last; logic [3:0] strb; logic [31:0] data;} word_t;
  typedef struct packed {logic [1:0] grant; logic lpm; logic last; logic [3:0] strb; logic [31:0] data;} obs_t;

  word_t vq[$], cq[$];        // words still to be presented by each source
  word_t vlist[$], clist[$];  // everything queued this test, for the model
  obs_t  obs[$], exp_q[$];
  bit    vid_took, cmd_took;
  int    rq_mode;             // 0 random, 1 every 2nd cycle, 2 manual
  bit    alt, la_auto;
  int    la_cnt;
  int    checks, errors;

  task automatic drive_sources();
    vid_req = (vq.size() != 0);
    {vid_last, vid_strb, vid_data} = vid_req ? {vq[0].last, vq[0].strb, vq[0].data} : 37'd0;
    cmd_req = (cq.size() != 0);
    {cmd_lp, cmd_last, cmd_strb, cmd_data} = cmd_req ? {cq[0].lp, cq[0].last, cq[0].strb, cq[0].data} : 38'd0;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (vid_took && vq.size() != 0) void'(vq.pop_front());
    if (cmd_took && cq.size() != 0) void'(cq.pop_front());
    drive_sources();
    case (rq_mode)
      0: iface_data_rqst = 1'($urandom_range(0, 1));
      1: begin alt = !alt; iface_data_rqst = alt; end
      default: ;
    endcase
    if (la_auto) lines_active = (la_cnt > 0);
    @(negedge clk_sys);
    vid_took = vid_ack;
    cmd_took = cmd_ack;
    if (iface_write_rqst && iface_data_rqst)
      obs.push_back(obs_t'({grant, iface_lpm_en, iface_last_word, iface_write_strb, iface_write_data}));
    if (iface_last_word) la_cnt = int'($urandom_range(0, 3));
    else if (iface_write_rqst) la_cnt = 100;
    else if (la_cnt > 0) la_cnt--;
  endtask

  task automatic add_vid(int len);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.lp = 1'b0; w.last = (i == len - 1); w.strb = 4'($urandom); w.data = $urandom;
      vq.push_back(w); vlist.push_back(w);
    end
  endtask

  task automatic add_cmd(int len, bit lp);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.lp = lp; w.last = (i == len - 1); w.strb = 4'($urandom); w.data = $urandom;
      cq.push_back(w); clist.push_back(w);
    end
  endtask

  task automatic clear_lists();
    vlist.delete(); clist.delete(); obs.delete(); exp_q.delete();
  endtask

  task automatic run_idle(int budget, output bit ok);
    int n = 0;
    tick();
    while ((vq.size() != 0 || cq.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    ok = (n < budget);
  endtask

  // Reference: all queued packets are present from the same cycle and every
  // source keeps its request up until its queue is empty.
  function automatic void build_expected();
    int vi = 0;
    int ci = 0;
    int starve = 0;
    bit take_cmd;
    exp_q.delete();
    while (vi < vlist.size() || ci < clist.size()) begin
      take_cmd = (vi >= vlist.size()) || (GUARD && ci < clist.size() && starve >= STARVE_LIMIT);
      if (take_cmd) begin
        starve = 0;
        do begin
          exp_q.push_back(obs_t'({2'b10, clist[ci].lp, clist[ci].last, clist[ci].strb, clist[ci].data}));
          ci++;
        end while (!clist[ci-1].last);
      end else begin
        starve = (ci < clist.size()) ? starve + 1 : 0;
        do begin
          exp_q.push_back(obs_t'({2'b01, 1'b0, vlist[vi].last, vlist[vi].strb, vlist[vi].data}));
          vi++;
        end while (!vlist[vi-1].last);
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++; if (iface_write_rqst !== 1'b0) begin errors++; $display("FAIL reset_rqst got %b want 0", iface_write_rqst); end
    checks++; if (iface_lpm_en !== 1'b0) begin errors++; $display("FAIL reset_lpm got %b want 0", iface_lpm_en); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({vid_ack, cmd_ack, iface_last_word} !== 3'b000) begin errors++; $display("FAIL reset_acks got %b want 000", {vid_ack, cmd_ack, iface_last_word}); end
    checks++; if ({iface_write_data, iface_write_strb} !== 36'd0) begin errors++; $display("FAIL reset_data got %h want 0", {iface_write_data, iface_write_strb}); end
    @(posedge clk_sys); #1 rst_n = 1'b1;
  endtask

  task automatic test_hs_video();
    word_t w;
    int acks = 0;
    int n = 0;
    bit seen = 0;
    clear_lists();
    la_auto = 1'b0; lines_active = 1'b1; rq_mode = 1; alt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w.lp = 0; w.last = (i == 2); w.strb = 4'hF; w.data = 32'hAAAA_0000 + 32'h1111_0000 * i;
      vq.push_back(w);
    end
    tick();
    checks++; if (iface_write_rqst !== 1'b0) begin errors++; $display("FAIL hs_rqst_early got %b want 0", iface_write_rqst); end
    tick();
    checks++; if (iface_write_rqst !== 1'b1) begin errors++; $display("FAIL hs_rqst_latency got %b want 1", iface_write_rqst); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL hs_grant got %b want 01", grant); end
    acks += vid_ack;
    while (!seen && n < 30) begin
      if (iface_last_word) begin
        seen = 1;
        checks++; if (iface_write_data !== 32'hCCCC_0000) begin errors++; $display("FAIL hs_last_data got %h want cccc0000", iface_write_data); end
      end else begin
        tick(); n++; acks += vid_ack;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL hs_last_timeout got none want last_word"); end
    checks++; if (acks !== 3) begin errors++; $display("FAIL hs_ack_count got %0d want 3", acks); end
    tick(); tick();
    lines_active = 1'b0;
    for (int i = 1; i <= MIN_GAP; i++) begin
      tick();
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL hs_gap_hold[%0d] got %b want 01", i, grant); end
    end
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL hs_gap_release got %b want 00", grant); end
    la_auto = 1'b1; la_cnt = 0;
  endtask

  task automatic test_lp_cmd();
    bit lpm_l[40], rq_l[40], lw_l[40];
    logic [1:0] gr_l[40];
    int acks = 0;
    int r = -1;
    int f = -1;
    int lw = -1;
    clear_lists();
    rq_mode = 2; iface_data_rqst = 1'b1;
    add_cmd(2, 1'b1);
    for (int i = 0; i < 36; i++) begin
      tick();
      lpm_l[i] = iface_lpm_en; rq_l[i] = iface_write_rqst; lw_l[i] = iface_last_word; gr_l[i] = grant;
      acks += cmd_ack;
      if (r < 0 && iface_lpm_en) r = i;
      if (f < 0 && iface_write_rqst) f = i;
      if (lw < 0 && iface_last_word) lw = i;
    end
    checks++; if (r !== 1) begin errors++; $display("FAIL lp_lpm_rise got %0d want 1", r); end
    checks++; if (f !== 2) begin errors++; $display("FAIL lp_rqst_latency got %0d want 2", f); end
    checks++; if (acks !== 2) begin errors++; $display("FAIL lp_ack_count got %0d want 2", acks); end
    if (lw >= 0 && lw < 30) begin
      checks++; if (gr_l[lw] !== 2'b10) begin errors++; $display("FAIL lp_grant got %b want 10", gr_l[lw]); end
      checks++; if ({lpm_l[lw], lpm_l[lw+1], lpm_l[lw+2]} !== 3'b110) begin errors++; $display("FAIL lp_lpm_fall got %b want 110", {lpm_l[lw], lpm_l[lw+1], lpm_l[lw+2]}); end
      checks++; if (rq_l[lw+1] !== 1'b0) begin errors++; $display("FAIL lp_hold_rqst got %b want 0", rq_l[lw+1]); end
    end else begin
      checks++; errors++; $display("FAIL lp_last_word got index %0d want 3", lw);
    end
  endtask

  task automatic test_priority();
    bit ok;
    clear_lists();
    rq_mode = 0;
    add_vid(1); add_cmd(1, 1'b0);
    run_idle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout got busy want idle"); end
    build_expected();
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL prio_len got %0d want %0d", obs.size(), exp_q.size()); end
    checks++; if (obs.size() == 0 || obs[0].grant !== 2'b01) begin errors++; $display("FAIL prio_first got %0d words want video first", obs.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL prio_word[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_clock_ready();
    bit ok;
    clear_lists();
    clock_ready = 1'b0; rq_mode = 2; iface_data_rqst = 1'b0;
    add_vid(2);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({iface_write_rqst, grant} !== 3'b000) begin errors++; $display("FAIL clkrdy_block[%0d] got %b want 000", i, {iface_write_rqst, grant}); end
    end
    clock_ready = 1'b1;
    tick();
    checks++; if (iface_write_rqst !== 1'b1) begin errors++; $display("FAIL clkrdy_start got %b want 1", iface_write_rqst); end
    clock_ready = 1'b0;
    add_vid(3);
    rq_mode = 0;
    repeat (40) tick();
    checks++; if (obs.size() != 2) begin errors++; $display("FAIL clkrdy_complete got %0d words want 2", obs.size()); end
    checks++; if ({iface_write_rqst, grant} !== 3'b000) begin errors++; $display("FAIL clkrdy_nogrant got %b want 000", {iface_write_rqst, grant}); end
    checks++; if (vq.size() != 3) begin errors++; $display("FAIL clkrdy_pending got %0d want 3", vq.size()); end
    clock_ready = 1'b1;
    run_idle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clkrdy_timeout got busy want idle"); end
    build_expected();
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL clkrdy_len got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL clkrdy_word[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 4; it++) begin
      clear_lists();
      rq_mode = 0;
      for (int p = 0; p < int'($urandom_range(1, 4)); p++) add_vid(int'($urandom_range(1, 4)));
      for (int p = 0; p < int'($urandom_range(1, 4)); p++) add_cmd(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      run_idle(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got busy want idle", it); end
      build_expected();
      checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len got %0d want %0d", it, obs.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs.size()) begin
        checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word[%0d] got %h want %h", it, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_starve();
    bit ok;
    int pos = -1;
    clear_lists();
    rq_mode = 0;
    for (int p = 0; p < 10; p++) add_vid(1);
    add_cmd(1, 1'b0);
    run_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL starve_timeout got busy want idle"); end
    foreach (obs[i]) if (pos < 0 && obs[i].grant == 2'b10) pos = i;
    checks++; if (pos !== (GUARD ? STARVE_LIMIT : 10)) begin errors++; $display("FAIL starve_cmd_pos got %0d want %0d", pos, GUARD ? STARVE_LIMIT : 10); end
    build_expected();
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL starve_len got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL starve_word[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_lists();
    rq_mode = 2; iface_data_rqst = 1'b0;
    add_vid(6);
    tick(); tick();
    checks++; if (iface_write_rqst !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", iface_write_rqst); end
    iface_data_rqst = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({iface_write_rqst, iface_lpm_en, grant, vid_ack, cmd_ack} !== 6'd0) begin errors++; $display("FAIL rstmid_outputs got %b want 000000", {iface_write_rqst, iface_lpm_en, grant, vid_ack, cmd_ack}); end
    repeat (2) @(negedge clk_sys);
    vq.delete(); clear_lists();
    vid_took = 0; cmd_took = 0; la_cnt = 0; lines_active = 1'b0;
    drive_sources();
    rst_n = 1'b1;
    checks++; if ({busy, grant} !== 3'b000) begin errors++; $display("FAIL rstmid_idle got %b want 000", {busy, grant}); end
    rq_mode = 0;
    add_vid(2);
    run_idle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got busy want idle"); end
    build_expected();
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word[%0d] got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    vid_took = 0; cmd_took = 0; alt = 0; la_auto = 1'b1; la_cnt = 0; rq_mode = 2;
    iface_data_rqst = 1'b0; lines_active = 1'b0; clock_ready = 1'b1;
    drive_sources();
    test_reset();
    test_hs_video();
    test_lp_cmd();
    test_priority();
    test_clock_ready();
    test_random();
    test_starve();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
